// File: rtl/scm_1r1w_port_arbiter.sv
`default_nettype none
// =============================================================================
// scm_1r1w_port_arbiter : shares a 1R1W byte-enable SCM among N_PORTS ports
// using independent round-robin read and write channels.     Rev 1.0
// =============================================================================
module scm_1r1w_port_arbiter #(
   parameter int N_PORTS    = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BYTE   = DATA_WIDTH/8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_PORTS-1:0]             req_i,
   input  logic [N_PORTS-1:0]             we_i,
   input  logic [N_PORTS*ADDR_WIDTH-1:0]  addr_i,
   input  logic [N_PORTS*DATA_WIDTH-1:0]  wdata_i,
   input  logic [N_PORTS*NUM_BYTE-1:0]    be_i,
   output logic [N_PORTS-1:0]             gnt_o,
   output logic [N_PORTS-1:0]             r_valid_o,
   output logic [DATA_WIDTH-1:0]          r_rdata_o,
   output logic                           scm_ren_o,
   output logic [ADDR_WIDTH-1:0]          scm_raddr_o,
   input  logic [DATA_WIDTH-1:0]          scm_rdata_i,
   output logic                           scm_wen_o,
   output logic [ADDR_WIDTH-1:0]          scm_waddr_o,
   output logic [DATA_WIDTH-1:0]          scm_wdata_o,
   output logic [NUM_BYTE-1:0]            scm_wbe_o
);

   localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   logic [N_PORTS-1:0]    w_rd_req;
   logic [N_PORTS-1:0]    w_wr_req;
   logic [ADDR_WIDTH-1:0] w_addr  [N_PORTS];
   logic [DATA_WIDTH-1:0] w_wdata [N_PORTS];
   logic [NUM_BYTE-1:0]   w_be    [N_PORTS];

   logic [IDX_W:0]        w_wsel;
   logic [IDX_W:0]        w_rsel;
   logic                  w_wgnt;
   logic                  w_rfound;
   logic                  w_rgnt;
   logic                  w_collide;
   logic [IDX_W-1:0]      w_widx;
   logic [IDX_W-1:0]      w_ridx;

   logic [IDX_W-1:0]      wptr_q, wptr_d;
   logic [IDX_W-1:0]      rptr_q, rptr_d;
   logic [IDX_W-1:0]      ridx_q, ridx_d;
   logic                  rvalid_q, rvalid_d;

   assign w_rd_req = req_i & ~we_i;
   assign w_wr_req = req_i &  we_i;

   for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
      assign w_addr[p]  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata[p] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      assign w_be[p]    = be_i[p*NUM_BYTE +: NUM_BYTE];
   end

   // Returns {found, index} of the first requester at or after ptr.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_PORTS-1:0] reqs,
                                              input logic [IDX_W-1:0]   ptr);
      logic [IDX_W:0] res;
      int             idx;
      res = '0;
      for (int k = N_PORTS-1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N_PORTS) idx = idx - N_PORTS;
         if (reqs[idx]) res = {1'b1, IDX_W'(idx)};
      end
      return res;
   endfunction

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (int'(i) == N_PORTS-1) ? '0 : i + IDX_W'(1);
   endfunction

   always_comb begin
      w_wsel = rr_pick(w_wr_req, wptr_q);
      w_rsel = rr_pick(w_rd_req, rptr_q);
   end

   assign w_wgnt   = w_wsel[IDX_W];
   assign w_widx   = w_wsel[IDX_W-1:0];
   assign w_rfound = w_rsel[IDX_W];
   assign w_ridx   = w_rsel[IDX_W-1:0];

   // A read to the address being written this cycle waits one cycle.
   assign w_collide = w_wgnt && w_rfound && (w_addr[w_ridx] == w_addr[w_widx]);
   assign w_rgnt    = w_rfound && !w_collide;

   always_comb begin
      gnt_o = '0;
      if (w_wgnt) gnt_o[w_widx] = 1'b1;
      if (w_rgnt) gnt_o[w_ridx] = 1'b1;
   end

   assign scm_ren_o   = w_rgnt;
   assign scm_raddr_o = w_rgnt ? w_addr[w_ridx]  : '0;
   assign scm_wen_o   = w_wgnt;
   assign scm_waddr_o = w_wgnt ? w_addr[w_widx]  : '0;
   assign scm_wdata_o = w_wgnt ? w_wdata[w_widx] : '0;
   assign scm_wbe_o   = w_wgnt ? w_be[w_widx]    : '0;

   always_comb begin
      r_valid_o = '0;
      if (rvalid_q) r_valid_o[ridx_q] = 1'b1;
   end

   assign r_rdata_o = scm_rdata_i;

   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      ridx_d   = ridx_q;
      rvalid_d = w_rgnt;
      if (w_wgnt) wptr_d = next_idx(w_widx);
      if (w_rgnt) begin
         rptr_d = next_idx(w_ridx);
         ridx_d = w_ridx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         ridx_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         ridx_q   <= ridx_d;
         rvalid_q <= rvalid_d;
      end
   end

endmodule
`default_nettype wire
